nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 144 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-word adder/subtractor that reuses one 4-bit ripple stage, one nibble per clock,
// least significant nibble first, with valid/ready handshakes on both sides.

module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  // Explicit ripple chain: carry[i] feeds bit i.
  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             in_ready_next;
  logic             out_valid_next;

  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             sub_reg;
  logic             c;
  logic [IDX_W-1:0] idx;

  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             accept_c;
  logic             last_c;

  assign accept_c = in_valid & in_ready;
  assign last_c   = (idx == LAST_IDX);

  // Current nibble of each operand; B is inverted for subtraction (cin supplies the +1).
  assign add_a = a_reg[{idx, 2'b00} +: 4];
  assign add_b = b_reg[{idx, 2'b00} +: 4] ^ {4{sub_reg}};

  four_bit_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (c),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are decoded from the next state and registered.
  always_comb begin
    in_ready_next  = (state_next == IDLE);
    out_valid_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      c         <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept_c) begin
      a_reg   <= op_a;
      b_reg   <= op_b;
      sub_reg <= sub;
      c       <= sub;
      idx     <= '0;
    end else if (state == RUN) begin
      result[{idx, 2'b00} +: 4] <= add_sum;
      c                         <= add_cout;
      idx                       <= last_c ? '0 : idx + IDX_W'(1);
      if (last_c) begin
        carry_out <= add_cout;
        overflow  <= (add_a[3] ^ add_sum[3]) & (add_b[3] ^ add_sum[3]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4) with a scoreboard of expected results.

module tb_nibble_serial_adder;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] res;
    logic         cy;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t         e;
    logic [W-1:0] be;
    logic [W:0]   wide;
    be     = s ? ~b : b;
    wide   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, s};
    e.res  = wide[W-1:0];
    e.cy   = wide[W];
    e.ov   = (a[W-1] ^ e.res[W-1]) & (be[W-1] ^ e.res[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait for the accepting edge; pushes the expectation there.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit keep);
    int guard = 0;
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb.push_back(model(a, b, s));
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Wait for out_valid, compare against the scoreboard, then complete the handshake.
  task automatic receive(input string tag, input bit chk_lat);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
    if (!out_valid) check({tag, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, 32'(result), 32'(e.res));
      check({tag, "_carry"}, 32'(carry_out), 32'(e.cy));
      check({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] held;
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b1;
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'h0);
    check("reset_carry", 32'(carry_out), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    send(16'h1234, 16'h0FCC, 1'b0, 1'b0);
    check("run_in_ready_low", 32'(in_ready), 32'd0);
    receive("add_basic", 1'b1);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    receive("add_ripple", 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    receive("add_signed_ovf", 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b0);
    receive("sub_borrow", 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b0);
    receive("sub_signed_ovf", 1'b1);
    send(16'hA5C3, 16'h5A3C, 1'b1, 1'b0);
    receive("sub_mixed", 1'b1);

    // Backpressure with a pending request waiting behind the result.
    out_ready = 1'b0;
    send(16'h1357, 16'h2468, 1'b0, 1'b1);
    op_a = 16'h4321; op_b = 16'h1111; sub = 1'b1;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    held = result;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result_stable", 32'(result), 32'(held));
    end
    receive("bp_first", 1'b0);
    @(posedge clk);
    sb.push_back(model(16'h4321, 16'h1111, 1'b1));
    #1;
    in_valid = 1'b0;
    check("bp_pending_accepted", 32'(in_ready), 32'd0);
    receive("bp_second", 1'b1);

    // Asynchronous abort two RUN edges into an operation.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'h0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_out_valid", 32'(out_valid), 32'd0);
    end
    check("abort_in_ready_after", 32'(in_ready), 32'd1);
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    receive("after_abort", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
